// File: rtl/flight_pkg.sv
// Purpose: shared flight-model widths and the update-scheduler FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package flight_pkg;

    // Coordinate and angle widths shared with plane_state.
    localparam int unsigned COORD_WIDTH = 32;
    localparam int unsigned ANGLE_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_VEL_START = 2'd2,
        ST_VEL_WAIT  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/update_tick_gen.sv
// Purpose: free-running divider that emits a one-cycle tick every DIV enabled cycles.
// Latency: tick is combinational from the count register, asserted while the count sits at DIV-1.
// Backpressure: none; the count is held at 0 while enable is low.
// Ports: clk, reset_n (async active-low), enable (level), tick (one-cycle pulse).
module update_tick_gen #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == TERM);

endmodule

// File: rtl/plane_update_scheduler.sv
// Purpose: sequences one plane_state update per frame tick, serving input/velocity requests.
// Latency: tick->update_enable 1 cycle; request->ready 1 cycle; vel_done->velocities_ready 1 cycle.
// Backpressure: requests are levels held until ready; ticks arriving mid-frame are dropped and counted.
// Ports: clk/reset_n; enable; pilot *_cmd in; ps_* handshake with plane_state; vel_* handshake
//        with the velocity engine; busy, timeout_flag, overrun_count, frame_count status.
module plane_update_scheduler
    import flight_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned UPDATE_HZ      = 60,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned COORD_WIDTH    = flight_pkg::COORD_WIDTH,
    parameter int unsigned ANGLE_WIDTH    = flight_pkg::ANGLE_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic signed [ANGLE_WIDTH-1:0] pitch_cmd,
    input  logic signed [ANGLE_WIDTH-1:0] roll_cmd,
    input  logic [7:0]                    throttle_cmd,
    output logic                          ps_update_enable,
    input  logic                          ps_update_done,
    input  logic                          ps_request_input,
    output logic                          ps_input_ready,
    output logic signed [ANGLE_WIDTH-1:0] ps_pitch_change,
    output logic signed [ANGLE_WIDTH-1:0] ps_roll_change,
    output logic [7:0]                    ps_throttle,
    input  logic                          ps_request_velocities,
    output logic                          ps_velocities_ready,
    output logic signed [COORD_WIDTH-1:0] ps_v_x,
    output logic signed [COORD_WIDTH-1:0] ps_v_y,
    output logic signed [COORD_WIDTH-1:0] ps_v_z,
    output logic                          vel_start,
    input  logic                          vel_done,
    input  logic signed [COORD_WIDTH-1:0] vel_x,
    input  logic signed [COORD_WIDTH-1:0] vel_y,
    input  logic signed [COORD_WIDTH-1:0] vel_z,
    output logic                          busy,
    output logic                          timeout_flag,
    output logic [7:0]                    overrun_count,
    output logic [15:0]                   frame_count
);

    localparam int unsigned TICK_DIV = CLK_HZ / UPDATE_HZ;
    localparam int unsigned WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    logic tick;

    update_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    sched_state_e                   state_q, state_d;
    logic [WDW-1:0]                 wd_q, wd_d;
    logic                           timeout_q, timeout_d;
    logic [7:0]                     overrun_q, overrun_d;
    logic [15:0]                    frame_q, frame_d;
    logic                           in_rdy_q, in_rdy_d;
    logic                           vel_rdy_q, vel_rdy_d;
    logic                           in_guard_q, vel_guard_q;
    logic signed [ANGLE_WIDTH-1:0]  pitch_q, pitch_d, roll_q, roll_d;
    logic [7:0]                     thr_q, thr_d;
    logic signed [COORD_WIDTH-1:0]  vx_q, vx_d, vy_q, vy_d, vz_q, vz_d;
    logic                           in_req_ok, vel_req_ok;

    // A request is still held high in the ready cycle and may linger one more cycle
    // after it; both cycles are masked so it is never served twice.
    assign in_req_ok  = ps_request_input      && !in_rdy_q  && !in_guard_q;
    assign vel_req_ok = ps_request_velocities && !vel_rdy_q && !vel_guard_q;

    always_comb begin
        state_d          = state_q;
        wd_d             = wd_q;
        timeout_d        = timeout_q;
        overrun_d        = overrun_q;
        frame_d          = frame_q;
        in_rdy_d         = 1'b0;
        vel_rdy_d        = 1'b0;
        pitch_d          = pitch_q;
        roll_d           = roll_q;
        thr_d            = thr_q;
        vx_d             = vx_q;
        vy_d             = vy_q;
        vz_d             = vz_q;
        ps_update_enable = 1'b0;
        vel_start        = 1'b0;

        if (tick && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_RUN;
                    wd_d    = '0;
                end
            end
            ST_RUN: begin
                ps_update_enable = 1'b1;
                if (ps_update_done) begin
                    state_d = ST_IDLE;
                    frame_d = frame_q + 16'd1;
                end else if (in_req_ok) begin
                    in_rdy_d = 1'b1;
                    pitch_d  = pitch_cmd;
                    roll_d   = roll_cmd;
                    thr_d    = throttle_cmd;
                end else if (!ps_request_input && vel_req_ok) begin
                    // Any input request still pending (even guarded) keeps input ahead of velocities.
                    state_d = ST_VEL_START;
                end
            end
            ST_VEL_START: begin
                // plane_state is still mid-update while the engine runs.
                ps_update_enable = 1'b1;
                vel_start        = 1'b1;
                state_d          = ST_VEL_WAIT;
            end
            ST_VEL_WAIT: begin
                ps_update_enable = 1'b1;
                if (vel_done) begin
                    vel_rdy_d = 1'b1;
                    vx_d      = vel_x;
                    vy_d      = vel_y;
                    vz_d      = vel_z;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog overrides everything in the final allowed cycle: abandon the frame,
        // suppress any ready pulse and leave the latched data untouched.
        if (state_q != ST_IDLE) begin
            if (wd_q == WD_LAST) begin
                state_d   = ST_IDLE;
                timeout_d = 1'b1;
                frame_d   = frame_q;
                in_rdy_d  = 1'b0;
                vel_rdy_d = 1'b0;
                pitch_d   = pitch_q;
                roll_d    = roll_q;
                thr_d     = thr_q;
                vx_d      = vx_q;
                vy_d      = vy_q;
                vz_d      = vz_q;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            overrun_q   <= '0;
            frame_q     <= '0;
            in_rdy_q    <= 1'b0;
            vel_rdy_q   <= 1'b0;
            in_guard_q  <= 1'b0;
            vel_guard_q <= 1'b0;
            pitch_q     <= '0;
            roll_q      <= '0;
            thr_q       <= '0;
            vx_q        <= '0;
            vy_q        <= '0;
            vz_q        <= '0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            frame_q     <= frame_d;
            in_rdy_q    <= in_rdy_d;
            vel_rdy_q   <= vel_rdy_d;
            in_guard_q  <= in_rdy_q;
            vel_guard_q <= vel_rdy_q;
            pitch_q     <= pitch_d;
            roll_q      <= roll_d;
            thr_q       <= thr_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            vz_q        <= vz_d;
        end
    end

    assign ps_input_ready      = in_rdy_q;
    assign ps_velocities_ready = vel_rdy_q;
    assign ps_pitch_change     = pitch_q;
    assign ps_roll_change      = roll_q;
    assign ps_throttle         = thr_q;
    assign ps_v_x              = vx_q;
    assign ps_v_y              = vy_q;
    assign ps_v_z              = vz_q;
    assign busy                = (state_q != ST_IDLE);
    assign timeout_flag        = timeout_q;
    assign overrun_count       = overrun_q;
    assign frame_count         = frame_q;

endmodule

// File: tb/tb_plane_update_scheduler.sv
// Purpose: directed check of framing, handshakes, arbitration, overrun, watchdog, enable and reset.
// Latency: outputs sampled 1 time unit after each rising edge; cycle index counted from reset release.
// Backpressure: the bench plays plane_state and the velocity engine with hand-scheduled levels.
module tb_plane_update_scheduler;

    localparam int CW = 32;
    localparam int AW = 16;

    logic                 clk;
    logic                 reset_n;
    logic                 enable;
    logic signed [AW-1:0] pitch_cmd, roll_cmd;
    logic [7:0]           throttle_cmd;
    logic                 ps_update_enable, ps_update_done;
    logic                 ps_request_input, ps_input_ready;
    logic signed [AW-1:0] ps_pitch_change, ps_roll_change;
    logic [7:0]           ps_throttle;
    logic                 ps_request_velocities, ps_velocities_ready;
    logic signed [CW-1:0] ps_v_x, ps_v_y, ps_v_z;
    logic                 vel_start, vel_done;
    logic signed [CW-1:0] vel_x, vel_y, vel_z;
    logic                 busy, timeout_flag;
    logic [7:0]           overrun_count;
    logic [15:0]          frame_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // The watchdog limit is above one tick period (100) so a held frame can span a tick,
    // yet below two periods so the timeout frame ends before a second dropped tick.
    plane_update_scheduler #(
        .CLK_HZ         (1000),
        .UPDATE_HZ      (10),
        .TIMEOUT_CYCLES (160),
        .COORD_WIDTH    (CW),
        .ANGLE_WIDTH    (AW)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .enable                (enable),
        .pitch_cmd             (pitch_cmd),
        .roll_cmd              (roll_cmd),
        .throttle_cmd          (throttle_cmd),
        .ps_update_enable      (ps_update_enable),
        .ps_update_done        (ps_update_done),
        .ps_request_input      (ps_request_input),
        .ps_input_ready        (ps_input_ready),
        .ps_pitch_change       (ps_pitch_change),
        .ps_roll_change        (ps_roll_change),
        .ps_throttle           (ps_throttle),
        .ps_request_velocities (ps_request_velocities),
        .ps_velocities_ready   (ps_velocities_ready),
        .ps_v_x                (ps_v_x),
        .ps_v_y                (ps_v_y),
        .ps_v_z                (ps_v_z),
        .vel_start             (vel_start),
        .vel_done              (vel_done),
        .vel_x                 (vel_x),
        .vel_y                 (vel_y),
        .vel_z                 (vel_z),
        .busy                  (busy),
        .timeout_flag          (timeout_flag),
        .overrun_count         (overrun_count),
        .frame_count           (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        int c0;
        logic seen;

        reset_n = 1'b0;
        enable = 1'b1;
        pitch_cmd = 16'sd5;
        roll_cmd = 16'sd3;
        throttle_cmd = 8'd100;
        ps_update_done = 1'b0;
        ps_request_input = 1'b0;
        ps_request_velocities = 1'b0;
        vel_done = 1'b0;
        vel_x = '0;
        vel_y = '0;
        vel_z = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_upd_en", 64'(ps_update_enable), 0);
        chk("rst_in_rdy", 64'(ps_input_ready), 0);
        chk("rst_vel_start", 64'(vel_start), 0);
        chk("rst_frames", 64'(frame_count), 0);
        chk("rst_overrun", 64'(overrun_count), 0);
        chk("rst_timeout", 64'(timeout_flag), 0);
        chk("rst_throttle", 64'(ps_throttle), 0);
        chk("rst_v_x", ps_v_x, 0);

        // Normal frame: tick at cycle 99, frame runs from 100.
        reset_n = 1'b1;
        cyc = 0;
        step_to(99);
        chk("pre_tick_upd_en", 64'(ps_update_enable), 0);
        step_to(100);
        chk("tick_upd_en", 64'(ps_update_enable), 1);
        chk("tick_busy", 64'(busy), 1);
        ps_request_input = 1'b1;
        step_to(101);
        chk("in_rdy", 64'(ps_input_ready), 1);
        chk("in_throttle", 64'(ps_throttle), 100);
        chk("in_pitch", ps_pitch_change, 5);
        chk("in_roll", ps_roll_change, 3);
        ps_request_input = 1'b0;
        step_to(102);
        chk("in_rdy_pulse", 64'(ps_input_ready), 0);
        ps_request_velocities = 1'b1;
        step_to(103);
        chk("vel_start", 64'(vel_start), 1);
        step_to(104);
        chk("vel_start_pulse", 64'(vel_start), 0);
        step_to(106);
        vel_done = 1'b1;
        vel_x = 32'sd7;
        vel_y = -32'sd10;
        vel_z = -32'sd1;
        step_to(107);
        vel_done = 1'b0;
        vel_x = 32'sd111;
        vel_y = 32'sd222;
        vel_z = 32'sd333;
        chk("vel_rdy", 64'(ps_velocities_ready), 1);
        chk("v_x", ps_v_x, 7);
        chk("v_y", ps_v_y, -10);
        chk("v_z", ps_v_z, -1);
        ps_request_velocities = 1'b0;
        step_to(108);
        chk("vel_rdy_pulse", 64'(ps_velocities_ready), 0);
        chk("v_y_held", ps_v_y, -10);
        ps_update_done = 1'b1;
        step_to(109);
        ps_update_done = 1'b0;
        chk("done_upd_en", 64'(ps_update_enable), 0);
        chk("done_busy", 64'(busy), 0);
        chk("frames_1", 64'(frame_count), 1);

        // Pilot input moves while no ready is pending; the latch must hold.
        pitch_cmd = -16'sd7;
        step_to(150);
        chk("pitch_hold", ps_pitch_change, 5);

        // Frame 2: simultaneous requests, input held one extra cycle.
        step_to(200);
        chk("f2_upd_en", 64'(ps_update_enable), 1);
        ps_request_input = 1'b1;
        ps_request_velocities = 1'b1;
        step_to(201);
        chk("sim_in_rdy", 64'(ps_input_ready), 1);
        chk("sim_pitch_new", ps_pitch_change, -7);
        chk("sim_no_vel_201", 64'(vel_start), 0);
        step_to(202);
        chk("sim_in_rdy_202", 64'(ps_input_ready), 0);
        chk("sim_no_vel_202", 64'(vel_start), 0);
        step_to(203);
        chk("sim_guard_203", 64'(ps_input_ready), 0);
        chk("sim_no_vel_203", 64'(vel_start), 0);
        ps_request_input = 1'b0;
        step_to(204);
        chk("sim_vel_start", 64'(vel_start), 1);
        chk("sim_in_rdy_204", 64'(ps_input_ready), 0);
        step_to(205);
        vel_done = 1'b1;
        vel_y = 32'sd20;
        step_to(206);
        vel_done = 1'b0;
        chk("sim_vel_rdy", 64'(ps_velocities_ready), 1);
        chk("sim_v_y", ps_v_y, 20);
        ps_request_velocities = 1'b0;

        // Overrun: done withheld until cycle 350, tick at 299 dropped.
        step_to(299);
        chk("ovr_before", 64'(overrun_count), 0);
        step_to(300);
        chk("ovr_count", 64'(overrun_count), 1);
        chk("ovr_busy", 64'(busy), 1);
        step_to(350);
        ps_update_done = 1'b1;
        step_to(351);
        ps_update_done = 1'b0;
        chk("ovr_done_busy", 64'(busy), 0);
        chk("frames_2", 64'(frame_count), 2);
        chk("ovr_no_timeout", 64'(timeout_flag), 0);
        step_to(399);
        chk("ovr_no_restart", 64'(busy), 0);

        // Timeout: frame from 400, engine never answers; tick at 499 also dropped.
        step_to(400);
        chk("to_start", 64'(busy), 1);
        ps_request_velocities = 1'b1;
        step_to(401);
        chk("to_vel_start", 64'(vel_start), 1);
        step_to(559);
        chk("to_pre_flag", 64'(timeout_flag), 0);
        chk("to_pre_busy", 64'(busy), 1);
        step_to(560);
        chk("to_flag", 64'(timeout_flag), 1);
        chk("to_busy", 64'(busy), 0);
        chk("to_upd_en", 64'(ps_update_enable), 0);
        chk("to_frames", 64'(frame_count), 2);
        chk("to_overrun", 64'(overrun_count), 2);
        ps_request_velocities = 1'b0;
        step_to(600);
        chk("to_fresh_frame", 64'(busy), 1);
        chk("to_sticky", 64'(timeout_flag), 1);

        // Enable drops mid-frame: frame completes, then no ticks.
        enable = 1'b0;
        ps_request_input = 1'b1;
        step_to(601);
        chk("en_in_rdy", 64'(ps_input_ready), 1);
        ps_request_input = 1'b0;
        step_to(605);
        ps_update_done = 1'b1;
        step_to(606);
        ps_update_done = 1'b0;
        chk("en_done_busy", 64'(busy), 0);
        chk("frames_3", 64'(frame_count), 3);
        seen = 1'b0;
        repeat (500) begin
            step();
            if (busy) seen = 1'b1;
        end
        chk("en_no_frame", 64'(seen), 0);
        chk("en_overrun", 64'(overrun_count), 2);

        // Re-enable: divider restarts from 0, so frame starts 100 cycles later.
        enable = 1'b1;
        c0 = cyc;
        step_to(c0 + 99);
        chk("reen_pre", 64'(busy), 0);
        step_to(c0 + 100);
        chk("reen_start", 64'(busy), 1);
        ps_request_velocities = 1'b1;
        step_to(c0 + 101);
        chk("reen_vel_start", 64'(vel_start), 1);
        step_to(c0 + 103);

        // Reset in VEL_WAIT takes effect without a clock edge.
        reset_n = 1'b0;
        #1;
        chk("ar_busy", 64'(busy), 0);
        chk("ar_upd_en", 64'(ps_update_enable), 0);
        chk("ar_frames", 64'(frame_count), 0);
        chk("ar_overrun", 64'(overrun_count), 0);
        chk("ar_timeout", 64'(timeout_flag), 0);
        chk("ar_pitch", ps_pitch_change, 0);
        chk("ar_v_y", ps_v_y, 0);
        chk("ar_throttle", 64'(ps_throttle), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        vel_done = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            step();
            if (ps_velocities_ready || vel_start || ps_input_ready || busy) seen = 1'b1;
        end
        chk("ar_no_pulses", 64'(seen), 0);
        vel_done = 1'b0;
        ps_request_velocities = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
